// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / hazard unit: default parameter
// values and the bit layout of one in-flight destination tag entry.
package fwd_hazard_unit_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_REG_W      = 3;
    localparam int DEF_NSTAGE     = 3;
    localparam int DEF_NSRC       = 2;
    localparam int DEF_LOAD_READY = 2;
    localparam int DEF_CNT_W      = 16;

    // Tag entry layout: flags in the low bits, destination index above them.
    localparam int ENT_VALID = 0;
    localparam int ENT_WR    = 1;
    localparam int ENT_LOAD  = 2;
    localparam int ENT_DST   = 3;

    // Width of one tag entry for a given register index width.
    function automatic int ent_w(input int reg_w);
        return 3 + reg_w;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-side bus of the forwarding / hazard unit. The decode stage is the
// master (drives instruction fields and data), the hazard unit is the slave.
interface fwd_hazard_unit_if
    import fwd_hazard_unit_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int NSTAGE = DEF_NSTAGE,
    parameter int NSRC   = DEF_NSRC,
    parameter int CNT_W  = DEF_CNT_W
);
    logic                     id_valid;
    logic [NSRC*REG_W-1:0]    id_src_sel;
    logic [NSRC-1:0]          id_src_used;
    logic [REG_W-1:0]         id_dst_sel;
    logic                     id_dst_wr;
    logic                     id_is_load;
    logic [NSRC*DATA_W-1:0]   rf_rdata;
    logic [NSTAGE*DATA_W-1:0] stage_data;
    logic                     flush;
    logic                     cnt_clr;
    logic                     stall;
    logic [NSRC*DATA_W-1:0]   fwd_data;
    logic [NSRC-1:0]          fwd_hit;
    logic [CNT_W-1:0]         stall_cnt;

    modport master (
        output id_valid, id_src_sel, id_src_used, id_dst_sel, id_dst_wr,
               id_is_load, rf_rdata, stage_data, flush, cnt_clr,
        input  stall, fwd_data, fwd_hit, stall_cnt
    );

    modport slave (
        input  id_valid, id_src_sel, id_src_used, id_dst_sel, id_dst_wr,
               id_is_load, rf_rdata, stage_data, flush, cnt_clr,
        output stall, fwd_data, fwd_hit, stall_cnt
    );

endinterface

// File: rtl/fwd_tag_stage.sv
// One destination-tag entry of the downstream pipeline. A bubble request
// clears the valid bit of the entry being loaded.
module fwd_tag_stage
    import fwd_hazard_unit_pkg::*;
#(
    parameter  int REG_W = DEF_REG_W,
    localparam int ENT_W = ent_w(REG_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bubble,
    input  logic [ENT_W-1:0] ent_in,
    output logic [ENT_W-1:0] ent_q
);

    logic [ENT_W-1:0] ent_d;

    // Next entry: incoming tag, invalidated when a bubble is inserted.
    // NOTE: combinational blocks assign every output a default first, so no latch is inferred.
    always_comb begin
        ent_d = ent_in;
        if (bubble) begin
            ent_d[ENT_VALID] = 1'b0;
        end
    end

    // Entry register; the whole pipeline advances every clock.
    // NOTE: state flops use non-blocking assignments so all stages sample the old values together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit beside decode. Tracks destination tags
// of NSTAGE downstream stages, forwards the youngest producer per read port,
// stalls decode on a not-yet-ready load and counts stall cycles.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_W      = DEF_REG_W,
    parameter int NSTAGE     = DEF_NSTAGE,
    parameter int NSRC       = DEF_NSRC,
    parameter int LOAD_READY = DEF_LOAD_READY,
    parameter int CNT_W      = DEF_CNT_W
) (
    input logic               clk,
    input logic               rst,
    fwd_hazard_unit_if.slave  bus
);

    localparam int ENT_W = ent_w(REG_W);

    logic [ENT_W-1:0]  ent_q   [NSTAGE];
    logic [ENT_W-1:0]  ent_in  [NSTAGE];
    logic [NSTAGE-1:0] ent_bubble;
    logic [ENT_W-1:0]  dec_ent;
    logic [NSRC-1:0]   port_blocked;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    assign stall = bus.id_valid & ~bus.flush & (|port_blocked);

    // Tag describing the instruction currently in decode.
    always_comb begin
        dec_ent                      = '0;
        dec_ent[ENT_VALID]           = 1'b1;
        dec_ent[ENT_WR]              = bus.id_dst_wr;
        dec_ent[ENT_LOAD]            = bus.id_is_load;
        dec_ent[ENT_DST +: REG_W]    = bus.id_dst_sel;
    end

    // Stage 1 takes decode (or a bubble); older stages shift unconditionally.
    for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
        if (s == 0) begin : g_first
            assign ent_in[s]     = dec_ent;
            assign ent_bubble[s] = ~(bus.id_valid & ~bus.flush & ~stall);
        end else begin : g_rest
            assign ent_in[s]     = ent_q[s-1];
            assign ent_bubble[s] = 1'b0;
        end

        fwd_tag_stage #(
            .REG_W (REG_W)
        ) u_tag (
            .clk    (clk),
            .rst    (rst),
            .bubble (ent_bubble[s]),
            .ent_in (ent_in[s]),
            .ent_q  (ent_q[s])
        );
    end

    // Per read port: find the youngest matching producer, then forward or block.
    for (genvar p = 0; p < NSRC; p++) begin : g_port
        logic [REG_W-1:0]  src;
        logic              used;
        logic              found;
        logic              hit;
        logic              blocked;
        logic [DATA_W-1:0] data;

        assign src  = bus.id_src_sel[p*REG_W +: REG_W];
        assign used = bus.id_src_used[p];

        // Scan youngest to oldest; the first match decides, older ones are ignored.
        always_comb begin
            found   = 1'b0;
            hit     = 1'b0;
            blocked = 1'b0;
            data    = bus.rf_rdata[p*DATA_W +: DATA_W];
            for (int k = 0; k < NSTAGE; k++) begin
                if (!found && used && ent_q[k][ENT_VALID] && ent_q[k][ENT_WR] &&
                    (ent_q[k][ENT_DST +: REG_W] == src)) begin
                    found = 1'b1;
                    if (!ent_q[k][ENT_LOAD] || (k + 1 >= LOAD_READY)) begin
                        hit  = 1'b1;
                        data = bus.stage_data[k*DATA_W +: DATA_W];
                    end else begin
                        blocked = 1'b1;
                    end
                end
            end
        end

        assign bus.fwd_data[p*DATA_W +: DATA_W] = data;
        assign bus.fwd_hit[p]                   = hit;
        assign port_blocked[p]                  = blocked;
    end

    // Stall counter: clear wins, otherwise saturating increment on stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.cnt_clr) begin
            stall_cnt_d = '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.stall_cnt = stall_cnt_q;

endmodule
